// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, output-port address and ALU op codes for the cpu datapath
package cpu_pkg;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 5;
  localparam int RAM_DEPTH = 1 << ADDR_W;

  // RAM writes to this address are redirected to the output port
  localparam logic [ADDR_W-1:0] OUT_ADDR = 5'h1F;

  typedef enum logic [4:0] {
    ALU_PASS_B = 5'b00000,
    ALU_ADD    = 5'b00001,
    ALU_SUB    = 5'b00010,
    ALU_AND    = 5'b00011,
    ALU_OR     = 5'b00100,
    ALU_XOR    = 5'b00101
  } alu_op_t;

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - combinational ALU; unlisted op codes pass operand A through
import cpu_pkg::*;

module cpu_alu (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_t           op,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    result = a;
    carry  = 1'b0;
    case (op)
      ALU_PASS_B: result = b;
      ALU_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      // carry on subtract means "no borrow"
      ALU_SUB: begin
        result = a - b;
        carry  = (a >= b);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      default: result = a;
    endcase
  end

endmodule

// File: rtl/cpu_datapath.sv
// rtl/cpu_datapath.sv - accumulator datapath with PC, flags, 32x8 RAM and handshaked I/O ports
import cpu_pkg::*;

module cpu_datapath (
  input  logic              clock,
  input  logic              ip_clear,
  input  logic              ip_clock_enable,
  input  logic              ip_MUXa,
  input  logic              ip_MUXb,
  input  logic              ip_MUXc,
  input  logic              ip_en_da,
  input  logic              ip_en_pc,
  input  logic              ip_en_in,
  input  logic              ip_RAM_we,
  input  logic              ip_ALU_s0,
  input  logic              ip_ALU_s1,
  input  logic              ip_ALU_s2,
  input  logic              ip_ALU_s3,
  input  logic              ip_ALU_s4,
  input  logic [DATA_W-1:0] ip_operand,
  input  logic [DATA_W-1:0] ip_in_data,
  input  logic              ip_in_valid,
  output logic              op_in_ack,
  output logic [DATA_W-1:0] op_out_data,
  output logic              op_out_valid,
  input  logic              ip_out_ready,
  output logic              op_carry,
  output logic              op_zero,
  output logic [DATA_W-1:0] op_pc,
  output logic [DATA_W-1:0] op_acc,
  output logic              op_stall
);

  logic [DATA_W-1:0] ram [RAM_DEPTH];
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  alu_op_t           alu_op;
  logic              out_write;
  logic              in_load;
  logic              advance;

  assign addr      = ip_operand[ADDR_W-1:0];
  assign alu_b     = ip_MUXa ? ip_operand : ram[addr];
  assign alu_op    = alu_op_t'({ip_ALU_s4, ip_ALU_s3, ip_ALU_s2, ip_ALU_s1, ip_ALU_s0});
  assign out_write = ip_RAM_we && (addr == OUT_ADDR);
  assign in_load   = ip_en_in & ip_en_da & ip_MUXb;

  // A full output register only blocks a new write if it is not draining this edge
  assign op_stall = (in_load & ~ip_in_valid) | (out_write & op_out_valid & ~ip_out_ready);
  assign advance  = ip_clock_enable & ~op_stall;

  cpu_alu u_alu (
    .a      (op_acc),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .carry  (alu_carry)
  );

  always_ff @(posedge clock) begin
    if (ip_clear) begin
      op_acc       <= '0;
      op_pc        <= '0;
      op_carry     <= 1'b0;
      op_zero      <= 1'b0;
      op_out_data  <= '0;
      op_out_valid <= 1'b0;
      op_in_ack    <= 1'b0;
    end else begin
      op_in_ack <= advance & in_load;
      if (advance && ip_en_da) begin
        if (ip_MUXb) begin
          op_acc <= ip_in_data;
        end else begin
          op_acc   <= alu_result;
          op_carry <= alu_carry;
          op_zero  <= (alu_result == '0);
        end
      end
      if (advance && ip_en_pc) begin
        op_pc <= ip_MUXc ? ip_operand : op_pc + 1'b1;
      end
      if (advance && out_write) begin
        op_out_data  <= op_acc;
        op_out_valid <= 1'b1;
      end else if (ip_clock_enable && ip_out_ready) begin
        op_out_valid <= 1'b0;
      end
    end
  end

  // RAM is deliberately left out of reset
  always_ff @(posedge clock) begin
    if (!ip_clear && advance && ip_RAM_we && !out_write) begin
      ram[addr] <= op_acc;
    end
  end

endmodule

// File: doc/cpu_datapath.md
CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port ip_clear, input, 1, reset; synchronous and active-high.
REQ-003 SHALL have port ip_clock_enable, input, 1; when 0, no architectural state changes.
REQ-004 SHALL have ports ip_MUXa, ip_MUXb, ip_MUXc, ip_en_da, ip_en_pc, ip_en_in, ip_RAM_we, ip_ALU_s0..ip_ALU_s4, input, 1 each; control word from the decoder.
REQ-005 SHALL have port ip_operand, input, 8, operand byte: RAM address in bits 4:0, immediate value or jump target.
REQ-006 SHALL have ports ip_in_data (input, 8) and ip_in_valid (input, 1); input-port data and its valid flag.
REQ-007 SHALL have port op_in_ack, output, 1; one-cycle pulse when input data is consumed.
REQ-008 SHALL have ports op_out_data (output, 8), op_out_valid (output, 1) and ip_out_ready (input, 1); output-port handshake.
REQ-009 SHALL have ports op_carry and op_zero, output, 1 each; registered flags returned to the decoder.
REQ-010 SHALL have ports op_pc (output, 8), op_acc (output, 8) and op_stall (output, 1).

Function
REQ-011 SHALL hold 8-bit accumulator ACC, 8-bit PC, carry and zero flags, and a 32x8 RAM addressed by ip_operand[4:0].
REQ-012 SHALL select ALU operand B by ip_MUXa: 0 = RAM[addr], 1 = ip_operand; operand A is always ACC.
REQ-013 SHALL decode ALU op {s4..s0}: 00000 pass B, 00001 A+B, 00010 A-B, 00011 AND, 00100 OR, 00101 XOR; all other codes pass A.
REQ-014 SHALL compute the carry as follows: add = bit 8 of the 9-bit sum; sub = 1 when A>=B (no borrow); all other ops = 0. Zero = (8-bit result == 0).
REQ-015 SHALL write ACC when ip_en_da=1, taking the ALU result if ip_MUXb=0 and ip_in_data if ip_MUXb=1.
REQ-016 SHALL update the carry and zero flags only on an ALU-sourced ACC write; input loads and all other cycles leave the flags unchanged.
REQ-017 SHALL update PC when ip_en_pc=1: ip_MUXc=0 gives PC+1 (wrapping 0xFF to 0x00), ip_MUXc=1 gives ip_operand.
REQ-018 SHALL write ACC to RAM[addr] when ip_RAM_we=1 and addr != 0x1F.
REQ-019 SHALL treat ip_RAM_we=1 with addr == 0x1F as an output write: load op_out_data with ACC and set op_out_valid; RAM is not written.
REQ-020 SHALL hold op_out_valid and op_out_data until ip_out_ready=1 is sampled, then clear op_out_valid on that edge.
REQ-021 SHALL assert op_stall combinationally when (ip_en_in & ip_en_da & ip_MUXb & !ip_in_valid) or (output write & op_out_valid & !ip_out_ready).
REQ-022 SHALL leave ACC, PC, flags and RAM unchanged in a stalled cycle; an output clear via ip_out_ready still proceeds.
REQ-023 SHALL pulse op_in_ack for exactly one cycle on the edge where an input load completes.
REQ-024 SHALL, when an output write coincides with ip_out_ready=1 and op_out_valid=1, accept the new data without stalling, leaving op_out_valid=1.
REQ-025 SHALL gate all of REQ-015..REQ-024 state updates with ip_clock_enable; op_in_ack stays 0 while ip_clock_enable=0.

Reset
REQ-026 SHALL, on ip_clear=1 at a rising edge, set ACC, PC, op_carry, op_zero, op_out_data, op_out_valid and op_in_ack to 0, regardless of ip_clock_enable.
REQ-027 SHALL give ip_clear priority over every simultaneous control, stall or handshake event; RAM contents are not reset.

Structure
REQ-028 SHALL take the ALU op codes, OUT_ADDR = 5'h1F and the data and address widths from shared package cpu_pkg.
REQ-029 SHALL place the ALU as a single combinational sub-module cpu_alu (A, B, op in; result, carry out).

Verification
REQ-030 SHALL verify: clear, then MUXa=1, operand 0x05, op 00000, en_da -> ACC=0x05, zero=0, carry=0.
REQ-031 SHALL verify: ACC=0xF0, add immediate 0x20 -> ACC=0x10, carry=1, zero=0; then sub immediate 0x10 -> ACC=0x00, carry=1, zero=1.
REQ-032 SHALL verify: en_pc, MUXc=1, operand 0x3A -> PC=0x3A; PC=0xFF with MUXc=0 -> PC=0x00.
REQ-033 SHALL verify: input load with ip_in_valid=0 for 3 cycles -> op_stall=1 and PC/ACC held; valid=1 with data 0x77 -> ACC=0x77, one-cycle op_in_ack.
REQ-034 SHALL verify: two output writes of 0x11 then 0x22 with ip_out_ready=0 -> second write stalls; ready=1 -> 0x11 clears, then 0x22 presented.
REQ-035 SHALL verify: ip_clear asserted mid-stall with op_out_valid=1 -> all outputs 0 next cycle and RAM[3] retains its value.
